// File: rtl/gpio_uart_rx.sv
// gpio_uart_rx: 8N1 UART receiver with mid-bit sampling, valid/ready byte output, framing and overrun flags.
module gpio_uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  if (CLKS_PER_BIT < 4) begin : g_bad_cpb
    $error("gpio_uart_rx: CLKS_PER_BIT must be at least 4");
  end
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t          state_q;
  logic            s1_q, s2_q, s3_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      idx_q;
  logic [7:0]      sh_q, data_q;
  logic            valid_q, fe_q, ovr_q;
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      {s1_q, s2_q, s3_q} <= 3'b111;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
      fe_q <= 1'b0;
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
        ovr_q   <= 1'b0;
      end
      case (state_q)
        IDLE: if (!s2_q && s3_q) begin
          state_q <= START;
          cnt_q   <= '0;
        end
        START: if (cnt_q == HALF_M1) begin
          state_q <= s2_q ? IDLE : DATA;
          cnt_q   <= '0;
          idx_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == LAST) begin
          sh_q  <= {s2_q, sh_q[7:1]};
          cnt_q <= '0;
          idx_q <= idx_q + 1'b1;
          if (idx_q == 3'd7) state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        // Returning to IDLE at mid-stop leaves half a bit to catch a back-to-back start edge.
        STOP: if (cnt_q == LAST) begin
          cnt_q   <= '0;
          state_q <= s2_q ? IDLE : BREAK;
          if (s2_q) begin
            data_q  <= sh_q;
            valid_q <= 1'b1;
            ovr_q   <= valid_q && !rx_ready;
          end else fe_q <= 1'b1;
        end else cnt_q <= cnt_q + 1'b1;
        BREAK: if (s2_q) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ovr_q;
  assign busy      = state_q != IDLE;
endmodule
